// File: rtl/rc4_stream.sv
// rc4_stream: RC4 stream-cipher core with valid/ready key, plaintext and
// ciphertext streams. It takes a run-time key length of 1..KEY_MAX bytes and
// runs the key schedule internally (one swap per cycle). It then encrypts one
// byte per clock under full backpressure.
//
// Optional feature: define RC4_DROP_EN to insert a DROP state. That state
// discards DROP_N keystream bytes between the key schedule and encryption.
//
// Ports:
//   CLK_IN, RESET_IN                    clock, synchronous active-high reset
//   START_IN / STOP_IN                  start (IDLE only) / abort session
//   KEY_LEN_IN                          key length L, latched on START
//   KEY_BYTE_IN/VALID_IN/READY_OUT      key byte stream, byte 0 first
//   PLAIN_BYTE_IN/VALID_IN/READY_OUT    plaintext stream
//   ENC_BYTE_OUT/VALID_OUT/READY_IN     ciphertext stream, 1-cycle latency
//   BUSY_OUT                            high outside IDLE
//   ERR_OUT                             1-cycle pulse on a rejected START
module rc4_stream #(
  parameter int KEY_MAX = 32,
  parameter int KLW     = 6,
  parameter int DROP_N  = 768
) (
  input  logic           CLK_IN,
  input  logic           RESET_IN,
  input  logic           START_IN,
  input  logic           STOP_IN,
  input  logic [KLW-1:0] KEY_LEN_IN,
  input  logic [7:0]     KEY_BYTE_IN,
  input  logic           KEY_VALID_IN,
  output logic           KEY_READY_OUT,
  input  logic [7:0]     PLAIN_BYTE_IN,
  input  logic           PLAIN_VALID_IN,
  output logic           PLAIN_READY_OUT,
  output logic [7:0]     ENC_BYTE_OUT,
  output logic           ENC_VALID_OUT,
  input  logic           ENC_READY_IN,
  output logic           BUSY_OUT,
  output logic           ERR_OUT
);

  localparam int KW = (KEY_MAX > 1) ? $clog2(KEY_MAX) : 1;

  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_KEY_LOAD, ST_KSA,
`ifdef RC4_DROP_EN
    ST_DROP,
`endif
    ST_PRGA
  } state_t;

  state_t         r_state, w_next;
  logic [7:0]     r_s   [256];
  logic [7:0]     r_key [KEY_MAX];
  logic [7:0]     r_i, r_j;
  logic [KW-1:0]  r_k;
  logic [KLW-1:0] r_len;
  logic           r_enc_valid, r_err;
  logic [7:0]     r_enc_byte;

  logic       w_len_ok, w_start_ok, w_k_last, w_key_hs, w_plain_rdy, w_plain_hs;
  logic       w_ksa_step, w_prga_step, w_drop_step;
  logic [7:0] w_ksa_si, w_ksa_j, w_ip, w_si, w_jp, w_sj, w_t, w_z;

  assign w_len_ok    = (KEY_LEN_IN != '0) && (KEY_LEN_IN <= KLW'(KEY_MAX));
  assign w_start_ok  = (r_state == ST_IDLE) && START_IN && w_len_ok;
  // k wraps at L by compare, so no modulo is needed.
  assign w_k_last    = (KLW'(r_k) == KLW'(r_len - 1'b1));
  assign w_key_hs    = (r_state == ST_KEY_LOAD) && KEY_VALID_IN && !STOP_IN;
  assign w_plain_rdy = (r_state == ST_PRGA) && (!r_enc_valid || ENC_READY_IN);
  // STOP beats a same-cycle handshake.
  assign w_plain_hs  = w_plain_rdy && PLAIN_VALID_IN && !STOP_IN;
  assign w_ksa_step  = (r_state == ST_KSA) && !STOP_IN;
`ifdef RC4_DROP_EN
  assign w_drop_step = (r_state == ST_DROP) && !STOP_IN;
`else
  assign w_drop_step = 1'b0;
`endif
  assign w_prga_step = w_plain_hs || w_drop_step;

  // KSA: j' = j + S[i] + K[k]
  assign w_ksa_si = r_s[r_i];
  assign w_ksa_j  = r_j + w_ksa_si + r_key[r_k];

  // PRGA step. z is read from the post-swap view: the two swapped slots are
  // forwarded so that S is not read after it is written.
  assign w_ip = r_i + 8'd1;
  assign w_si = r_s[w_ip];
  assign w_jp = r_j + w_si;
  assign w_sj = r_s[w_jp];
  assign w_t  = w_si + w_sj;
  assign w_z  = (w_t == w_ip) ? w_sj :
                (w_t == w_jp) ? w_si : r_s[w_t];

`ifdef RC4_DROP_EN
  localparam int DCW = (DROP_N > 1) ? $clog2(DROP_N) : 1;
  logic [DCW-1:0] r_drop;
  logic           w_drop_last;
  assign w_drop_last = (r_drop == DCW'(DROP_N - 1));
`endif

  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) r_state <= ST_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (START_IN && w_len_ok) w_next = ST_INIT;
      ST_INIT:     w_next = ST_KEY_LOAD;
      ST_KEY_LOAD: if (KEY_VALID_IN && w_k_last) w_next = ST_KSA;
      ST_KSA:
        if (r_i == 8'hff) begin
`ifdef RC4_DROP_EN
          w_next = (DROP_N == 0) ? ST_PRGA : ST_DROP;
`else
          w_next = ST_PRGA;
`endif
        end
`ifdef RC4_DROP_EN
      ST_DROP:     if (w_drop_last) w_next = ST_PRGA;
`endif
      ST_PRGA:     w_next = ST_PRGA;
      default:     w_next = ST_IDLE;
    endcase
    if (STOP_IN && (r_state != ST_IDLE)) w_next = ST_IDLE;
  end

  // Control registers: indices, length, output stage, error pulse.
  always_ff @(posedge CLK_IN) begin
    if (RESET_IN) begin
      r_i         <= '0;
      r_j         <= '0;
      r_k         <= '0;
      r_len       <= '0;
      r_enc_valid <= 1'b0;
      r_enc_byte  <= '0;
      r_err       <= 1'b0;
`ifdef RC4_DROP_EN
      r_drop      <= '0;
`endif
    end else begin
      r_err <= (r_state == ST_IDLE) && START_IN && !w_len_ok;
      if (w_start_ok) r_len <= KEY_LEN_IN;

      if (STOP_IN && (r_state != ST_IDLE)) r_enc_valid <= 1'b0;
      else if (w_plain_hs) begin
        r_enc_valid <= 1'b1;
        r_enc_byte  <= PLAIN_BYTE_IN ^ w_z;
      end else if (ENC_READY_IN) r_enc_valid <= 1'b0;

      if (r_state == ST_INIT && !STOP_IN) begin
        r_i <= '0;
        r_j <= '0;
        r_k <= '0;
      end else if (w_key_hs) begin
        r_k <= w_k_last ? '0 : r_k + 1'b1;
      end else if (w_ksa_step) begin
        r_i <= r_i + 8'd1;              // wraps to 0 on the last round
        r_j <= (r_i == 8'hff) ? 8'd0 : w_ksa_j;
        r_k <= w_k_last ? '0 : r_k + 1'b1;
      end else if (w_prga_step) begin
        r_i <= w_ip;
        r_j <= w_jp;
      end

`ifdef RC4_DROP_EN
      if (r_state == ST_KSA) r_drop <= '0;
      else if (w_drop_step)  r_drop <= r_drop + 1'b1;
`endif
    end
  end

  // S-box and key buffer carry no reset; INIT defines them before use.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_IN) begin
      if (r_state == ST_INIT && !STOP_IN) begin
        for (int n = 0; n < 256; n++) r_s[n] <= 8'(n);
      end else if (w_ksa_step) begin
        r_s[r_i]     <= r_s[w_ksa_j];
        r_s[w_ksa_j] <= w_ksa_si;
      end else if (w_prga_step) begin
        r_s[w_ip] <= w_sj;
        r_s[w_jp] <= w_si;
      end
    end
  end

  always_ff @(posedge CLK_IN) begin
    if (w_key_hs) r_key[r_k] <= KEY_BYTE_IN;
  end

  assign KEY_READY_OUT   = (r_state == ST_KEY_LOAD);
  assign PLAIN_READY_OUT = w_plain_rdy;
  assign ENC_BYTE_OUT    = r_enc_byte;
  assign ENC_VALID_OUT   = r_enc_valid;
  assign BUSY_OUT        = (r_state != ST_IDLE);
  assign ERR_OUT         = r_err;

endmodule

// File: tb/tb_rc4_stream.sv
module tb_rc4_stream;
  logic       clk = 1'b0;
  logic       rst, start, stop, kvalid, pvalid, erdy;
  logic [5:0] klen;
  logic [7:0] kbyte, pbyte;
  logic       krdy, prdy, evalid, busy, err;
  logic [7:0] ebyte;

  int cyc = 0;
  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] g_key [32];
  logic [7:0] g_pt  [64];
  logic [7:0] g_ct  [64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rc4_stream dut (
    .CLK_IN(clk), .RESET_IN(rst), .START_IN(start), .STOP_IN(stop),
    .KEY_LEN_IN(klen), .KEY_BYTE_IN(kbyte), .KEY_VALID_IN(kvalid), .KEY_READY_OUT(krdy),
    .PLAIN_BYTE_IN(pbyte), .PLAIN_VALID_IN(pvalid), .PLAIN_READY_OUT(prdy),
    .ENC_BYTE_OUT(ebyte), .ENC_VALID_OUT(evalid), .ENC_READY_IN(erdy),
    .BUSY_OUT(busy), .ERR_OUT(err)
  );

  // Reference RC4, written straight from the algorithm, fills g_ct.
  function automatic void rc4_model(input int L, input int n);
    logic [7:0] s [256];
    logic [7:0] i, j, t, tmp;
    for (int k = 0; k < 256; k++) s[k] = k[7:0];
    j = 8'd0;
    for (int k = 0; k < 256; k++) begin
      j = j + s[k] + g_key[k % L];
      tmp = s[k]; s[k] = s[j]; s[j] = tmp;
    end
    i = 8'd0; j = 8'd0;
    for (int p = 0; p < n; p++) begin
      i = i + 8'd1;
      j = j + s[i];
      tmp = s[i]; s[i] = s[j]; s[j] = tmp;
      t = s[i] + s[j];
      g_ct[p] = g_pt[p] ^ s[t];
    end
  endfunction

  // Drives one session: START, key bytes back to back, and the plaintext
  // stream. Expected ciphertext is queued on each plaintext handshake and
  // popped on each ciphertext handshake. mode 0: sink always ready,
  // 1: sink stalls 5 cycles on the first output, 2: random sink stalls.
  task automatic run_session(input string tag, input int L, input int n,
                             input int mode, output int first_rdy);
    logic [7:0] q[$];
    logic [7:0] exp_b;
    int c0, kidx, pidx, oidx, stall, budget;
    @(negedge clk);
    klen = 6'(L); start = 1'b1; c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    kidx = 0; pidx = 0; oidx = 0; stall = 0; budget = 0; first_rdy = -1;
    while (oidx < n && budget < 3000) begin
      kvalid = (kidx < L);
      kbyte  = (kidx < L) ? g_key[kidx] : 8'h00;
      pvalid = (pidx < n);
      pbyte  = (pidx < n) ? g_pt[pidx] : 8'h00;
      #1;
      case (mode)
        1:       erdy = !(evalid && stall < 5);
        2:       erdy = ($urandom_range(0, 3) != 0);
        default: erdy = 1'b1;
      endcase
      #1;
      if (first_rdy < 0 && prdy) first_rdy = cyc - c0;
      if (mode == 1 && !erdy) begin
        stall++;
        n_cmp++;
        if (ebyte !== g_ct[0]) begin
          n_fail++;
          $display("FAIL %s stall_hold: ENC_BYTE_OUT=%02h want %02h", tag, ebyte, g_ct[0]);
        end
        n_cmp++;
        if (prdy !== 1'b0) begin
          n_fail++;
          $display("FAIL %s stall_plain_ready: PLAIN_READY_OUT=%b want 0", tag, prdy);
        end
      end
      if (evalid && erdy) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL %s out[%0d]: unexpected byte %02h, nothing pending", tag, oidx, ebyte);
        end else begin
          exp_b = q.pop_front();
          if (ebyte !== exp_b) begin
            n_fail++;
            $display("FAIL %s out[%0d]: got %02h want %02h", tag, oidx, ebyte, exp_b);
          end
        end
        oidx++;
      end
      if (pvalid && prdy) begin
        q.push_back(g_ct[pidx]);
        pidx++;
      end
      if (kvalid && krdy) kidx++;
      @(negedge clk);
      budget++;
    end
    n_cmp++;
    if (oidx < n) begin
      n_fail++;
      $display("FAIL %s timeout: %0d of %0d bytes out", tag, oidx, n);
    end
    kvalid = 1'b0; pvalid = 1'b0; erdy = 1'b1;
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
  endtask

  task automatic load_key_vector();
    logic [71:0] pt;
    pt = 72'h506c61696e74657874;
    g_key[0] = 8'h4b; g_key[1] = 8'h65; g_key[2] = 8'h79;
    for (int i = 0; i < 9; i++) g_pt[i] = pt[71-8*i -: 8];
    pt = 72'hbbf316e8d940af0ad3;
    for (int i = 0; i < 9; i++) g_ct[i] = pt[71-8*i -: 8];
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (evalid !== 1'b0) begin n_fail++; $display("FAIL reset ENC_VALID_OUT=%b want 0", evalid); end
    n_cmp++; if (ebyte !== 8'h00) begin n_fail++; $display("FAIL reset ENC_BYTE_OUT=%02h want 00", ebyte); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset BUSY_OUT=%b want 0", busy); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset ERR_OUT=%b want 0", err); end
    n_cmp++; if (krdy !== 1'b0) begin n_fail++; $display("FAIL reset KEY_READY_OUT=%b want 0", krdy); end
    n_cmp++; if (prdy !== 1'b0) begin n_fail++; $display("FAIL reset PLAIN_READY_OUT=%b want 0", prdy); end
  endtask

  task automatic test_key_vector();
    int fr;
    load_key_vector();
    run_session("key_vec", 3, 9, 0, fr);
    n_cmp++;
    if (fr !== 261) begin n_fail++; $display("FAIL key_vec first_ready cycle=%0d want 261", fr); end
  endtask

  task automatic test_long_key();
    logic [255:0] v;
    int fr;
    v = 256'hae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405;
    for (int i = 0; i < 32; i++) g_key[i] = v[255-8*i -: 8];
    v = 256'h3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595;
    for (int i = 0; i < 32; i++) g_pt[i] = v[255-8*i -: 8];
    v = 256'h2280c9676c8f5c52aba8d42611f85e7ca961a2117d3cfc8236a6051bbfc5f179;
    for (int i = 0; i < 32; i++) g_ct[i] = v[255-8*i -: 8];
    run_session("long_key", 32, 32, 0, fr);
    n_cmp++;
    if (fr !== 290) begin n_fail++; $display("FAIL long_key first_ready cycle=%0d want 290", fr); end
  endtask

  task automatic test_backpressure();
    logic [79:0] ks;
    int fr;
    ks = 80'heb9f7781b734ca72a719;
    g_key[0] = 8'h4b; g_key[1] = 8'h65; g_key[2] = 8'h79;
    for (int i = 0; i < 10; i++) begin
      g_pt[i] = 8'h00;
      g_ct[i] = ks[79-8*i -: 8];
    end
    run_session("backpressure", 3, 10, 1, fr);
  endtask

  task automatic test_bad_start();
    int lens [2];
    int pulses;
    lens[0] = 0; lens[1] = 33;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      klen = 6'(lens[t]); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
        if (err === 1'b1) pulses++;
        n_cmp++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL bad_start len=%0d BUSY_OUT=%b want 0", lens[t], busy);
        end
        @(negedge clk);
      end
      n_cmp++;
      if (pulses != 1) begin
        n_fail++;
        $display("FAIL bad_start len=%0d ERR_OUT pulses=%0d want 1", lens[t], pulses);
      end
    end
  endtask

  task automatic test_stop_ksa();
    int k, fr;
    load_key_vector();
    @(negedge clk);
    klen = 6'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    for (int c = 0; c < 100; c++) begin
      kvalid = (k < 3);
      kbyte  = (k < 3) ? g_key[k] : 8'h00;
      #1;
      if (kvalid && krdy) k++;
      @(negedge clk);
    end
    kvalid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL stop_ksa pre BUSY_OUT=%b want 1", busy); end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    n_cmp++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL stop_ksa BUSY_OUT=%b want 0", busy); end
    n_cmp++;
    if (err !== 1'b0) begin n_fail++; $display("FAIL stop_ksa ERR_OUT=%b want 0", err); end
    run_session("after_stop", 3, 9, 0, fr);
    n_cmp++;
    if (fr !== 261) begin n_fail++; $display("FAIL after_stop first_ready cycle=%0d want 261", fr); end
  endtask

  task automatic test_random();
    int fr;
    for (int i = 0; i < 5; i++)  g_key[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 24; i++) g_pt[i]  = 8'($urandom_range(0, 255));
    rc4_model(5, 24);
    run_session("random", 5, 24, 2, fr);
    n_cmp++;
    if (fr !== 263) begin n_fail++; $display("FAIL random first_ready cycle=%0d want 263", fr); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stop = 1'b0; klen = '0;
    kbyte = '0; kvalid = 1'b0; pbyte = '0; pvalid = 1'b0; erdy = 1'b1;
    test_reset();
    test_key_vector();
    test_long_key();
    test_backpressure();
    test_bad_start();
    test_stop_ksa();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/rc4_stream.md
# rc4_stream

Parametrised RC4 stream-cipher core with valid/ready streaming on the key, plaintext and ciphertext paths. It replaces the fixed-key-length START/HOLD-driven RC4 engine. It runs the key schedule internally from a key of run-time length up to `KEY_MAX` bytes, then encrypts one byte per clock under full backpressure. It sits between a byte-wide key/plaintext source and a byte-wide ciphertext sink.

## Interface
- `KEY_MAX`, 32: maximum key length in bytes; key buffer depth.
- `KLW`, 6: width of `KEY_LEN_IN`; must hold `KEY_MAX`.
- `DROP_N`, 768: keystream bytes discarded after KSA. Used only with `RC4_DROP_EN`.

Ports:
- `CLK_IN` in 1: the single clock; everything is clocked on its rising edge.
- `RESET_IN` in 1: synchronous, active-high reset.
- `START_IN` in 1: start a session. Sampled only in IDLE.
- `STOP_IN` in 1: abort the session and return to IDLE.
- `KEY_LEN_IN` in KLW: key length L. Latched when START is accepted.
- `KEY_BYTE_IN` in 8 / `KEY_VALID_IN` in 1 / `KEY_READY_OUT` out 1: key byte stream, key byte 0 first.
- `PLAIN_BYTE_IN` in 8 / `PLAIN_VALID_IN` in 1 / `PLAIN_READY_OUT` out 1: plaintext stream.
- `ENC_BYTE_OUT` out 8 / `ENC_VALID_OUT` out 1 / `ENC_READY_IN` in 1: ciphertext stream.
- `BUSY_OUT` out 1: high in every state except IDLE.
- `ERR_OUT` out 1: one-cycle pulse when START is rejected.

## Operation
- State: S[0..255] as an 8-bit register array; key buffer K[0..KEY_MAX-1]; 8-bit `i` and `j`; key index `k`, which wraps at L (no modulo hardware).
- IDLE, START_IN=1, 1<=L<=KEY_MAX: latch L and go to INIT.
- IDLE, START_IN=1, L==0 or L>KEY_MAX: pulse ERR_OUT for one cycle and stay in IDLE.
- INIT, 1 cycle: S[n]=n for all n in parallel; i=j=k=0; go to KEY_LOAD.
- KEY_LOAD: KEY_READY_OUT=1. Each handshake writes K[k] and increments k. After byte L-1 is accepted, clear k and go to KSA.
- KSA, exactly 256 cycles, one swap per cycle:
  - j' = j + S[i] + K[k], mod 256.
  - Swap S[i] and S[j'].
  - i += 1; k = (k==L-1) ? 0 : k+1.
  - After i wraps from 255 to 0, clear i and j and go to DROP (macro) or PRGA.
- PRGA step:
  - i' = i+1; j' = j+S[i'].
  - t = S[i'] + S[j'], using pre-swap values, mod 256.
  - Swap S[i'] and S[j'].
  - Keystream byte z = post-swap S[t]: if t==i' then old S[j']; if t==j' then old S[i']; else S[t].
  - ENC byte = PLAIN ^ z.
- PRGA advances only on a plaintext handshake. The keystream never advances without consuming a plaintext byte.
- PLAIN_READY_OUT = (state==PRGA) && (!ENC_VALID_OUT || ENC_READY_IN).
- The session stays in PRGA indefinitely until STOP_IN or RESET_IN.
- Arithmetic is mod 256 throughout; all S-box indices are 8 bits.

## Timing
- Reset values: all outputs 0; state IDLE; i=j=k=0. S and K contents are don't-care until INIT.
- START accepted at cycle 0 -> INIT at cycle 1 -> KEY_LOAD at cycle 2.
- With back-to-back key bytes, KSA starts at cycle 2+L.
- PLAIN_READY_OUT first rises at cycle 2+L+256, plus DROP_N when the macro is defined.
- Ciphertext latency is 1 cycle: a plaintext byte accepted at edge n gives ENC_VALID_OUT=1 with its ENC_BYTE_OUT after edge n. Sustained throughput is 1 byte/cycle.
- While ENC_VALID_OUT=1 and ENC_READY_IN=0: ENC_BYTE_OUT is held stable, PLAIN_READY_OUT=0, and S, i, j are frozen.
- Simultaneous output drain and new input: ENC_VALID_OUT stays 1 and ENC_BYTE_OUT updates.
- STOP_IN in any non-IDLE state: IDLE on the next cycle. ENC_VALID_OUT is cleared, a pending ciphertext byte is discarded, and no ERR_OUT is raised.
- RESET_IN mid-session behaves like STOP and also clears i, j, k.
- If STOP_IN and a handshake occur in the same cycle, STOP wins and the handshake is not consumed.
- START_IN while busy is ignored.
- KEY_VALID_IN outside KEY_LOAD is ignored.

## Configuration
- `RC4_DROP_EN` defined:
  - DROP state between KSA and PRGA runs DROP_N PRGA steps, one per cycle, discarding z.
  - PLAIN_READY_OUT=0 and BUSY_OUT=1 throughout DROP.
  - DROP_N=0 skips the state.
- `RC4_DROP_EN` undefined: no DROP state or counter; KSA goes directly to PRGA and DROP_N is ignored.

## Test plan
- Key "Key" (4b 65 79), L=3, plaintext "Plaintext" -> ciphertext bb f3 16 e8 d9 40 af 0a d3. First PLAIN_READY_OUT at cycle 261 after START.
- 32-byte key ae6c3c41884d35df3ab5adf30f5b2d360938c658341886b0ba510b421e5ab405, plaintext 3ae280d0d5cd70d8e0f81300dc9031a2e0f8512cb35a7579fd79575cf287c595 -> ciphertext 2280c9676c8f5c52aba8d42611f85e7ca961a2117d3cfc8236a6051bbfc5f179.
- Backpressure: key "Key", plaintext 00 stream, ENC_READY_IN low for 5 cycles after the first output:
  - ENC_BYTE_OUT holds eb and PLAIN_READY_OUT=0 during the stall.
  - Full output afterwards is eb 9f 77 81 b7 34 ca 72 a7 19 with no loss or duplicate.
- START with KEY_LEN_IN=0, then with KEY_MAX+1 -> one ERR_OUT pulse each; BUSY_OUT stays 0.
- STOP_IN asserted mid-KSA, then a fresh START with key "Key" -> IDLE next cycle; the new session reproduces the first vector exactly.
- `RC4_DROP_EN`, DROP_N=1, key "Key", plaintext 00 00 -> ciphertext 9f 77; ready rises at cycle 262.
